// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//
// Serial transmit stage of the UART link. Bytes arrive over a valid/ready
// handshake into a one-entry holding register and are serialised LSB first
// into an asynchronous frame on txd. Because the holding register can be
// refilled while a frame is shifting, consecutive frames leave with no idle
// gap between them.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined     -> 11-bit frame: start, d0..d7, even parity, stop
//   not defined -> 10-bit frame: start, d0..d7, stop
//
// Ports
//   clk      in   1  system clock, rising edge
//   rst      in   1  synchronous active-high reset
//   n        in   4  clock cycles per bit. Sampled at frame start. 0 acts as 1
//   data     in   8  byte to transmit
//   valid    in   1  data is valid
//   ready    out  1  holding register empty (registered)
//   txd      out  1  serial line, idles high
//   busy     out  1  a frame is being shifted out
//   tx_done  out  1  one-cycle pulse on the last cycle of the stop bit
// -----------------------------------------------------------------------------
module uart_transmitter (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       txd,
    output logic       busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t     state_reg,     state_next;
    logic [7:0] hold_reg,      hold_next;
    logic       hold_full_reg, hold_full_next;
    logic       ready_reg,     ready_next;
    logic [7:0] shift_reg,     shift_next;
    logic [3:0] bit_len_reg,   bit_len_next;
    logic [3:0] cnt_reg,       cnt_next;
    logic [2:0] bit_idx_reg,   bit_idx_next;
`ifdef UART_TX_PARITY_EN
    logic       parity_reg,    parity_next;
`endif

    // Last clock cycle of the current bit period.
    logic bit_last;
    // Holding register moves into the shifter on this edge.
    logic load;
    logic accept;

    assign bit_last = (cnt_reg == (bit_len_reg - 4'd1));
    assign accept   = valid && ready_reg;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        shift_next     = shift_reg;
        bit_len_next   = bit_len_reg;
        cnt_next       = cnt_reg;
        bit_idx_next   = bit_idx_reg;
`ifdef UART_TX_PARITY_EN
        parity_next    = parity_reg;
`endif
        load           = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (hold_full_reg) begin
                    load = 1'b1;
                end
            end

            ST_START: begin
                if (bit_last) begin
                    cnt_next   = 4'd0;
                    state_next = ST_DATA;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end

            ST_DATA: begin
                if (bit_last) begin
                    cnt_next   = 4'd0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        bit_idx_next = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_next   = ST_PARITY;
`else
                        state_next   = ST_STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_last) begin
                    cnt_next   = 4'd0;
                    state_next = ST_STOP;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
`endif

            ST_STOP: begin
                if (bit_last) begin
                    cnt_next = 4'd0;
                    // A queued byte starts immediately, giving back-to-back frames.
                    if (hold_full_reg) begin
                        load = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (load) begin
            state_next     = ST_START;
            shift_next     = hold_reg;
            bit_len_next   = (n == 4'd0) ? 4'd1 : n;
            cnt_next       = 4'd0;
            bit_idx_next   = 3'd0;
            hold_full_next = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_next    = ^hold_reg;
`endif
        end

        // accept only happens with the holding register empty, so it can
        // never coincide with load (which needs it full).
        if (accept) begin
            hold_next      = data;
            hold_full_next = 1'b1;
        end

        ready_next = !hold_full_next;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            hold_reg      <= 8'd0;
            hold_full_reg <= 1'b0;
            ready_reg     <= 1'b1;
            shift_reg     <= 8'd0;
            bit_len_reg   <= 4'd0;
            cnt_reg       <= 4'd0;
            bit_idx_reg   <= 3'd0;
`ifdef UART_TX_PARITY_EN
            parity_reg    <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            ready_reg     <= ready_next;
            shift_reg     <= shift_next;
            bit_len_reg   <= bit_len_next;
            cnt_reg       <= cnt_next;
            bit_idx_reg   <= bit_idx_next;
`ifdef UART_TX_PARITY_EN
            parity_reg    <= parity_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        txd = 1'b1;
        case (state_reg)
            ST_START:  txd = 1'b0;
            ST_DATA:   txd = shift_reg[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd = parity_reg;
`endif
            default:   txd = 1'b1;
        endcase
    end

    assign ready   = ready_reg;
    assign busy    = (state_reg != ST_IDLE);
    assign tx_done = (state_reg == ST_STOP) && bit_last;

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
//
// Directed bench for uart_transmitter. Inputs change 1 time unit after the
// rising edge and outputs are sampled at the same point, so every sample
// reflects the state produced by the preceding edge.
// Frame length follows UART_TX_PARITY_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] n;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       txd;
    logic       busy;
    logic       tx_done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    uart_transmitter dut (
        .clk     (clk),
        .rst     (rst),
        .n       (n),
        .data    (data),
        .valid   (valid),
        .ready   (ready),
        .txd     (txd),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Expected line level for bit i of a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Walks one whole frame starting at its first START cycle (already
    // sampled). release_valid drops valid after the first edge of the frame,
    // on which a second byte is expected to be accepted. n is changed to n_new
    // once the frame reaches cycle n_change_cycle.
    task automatic check_frame(input logic [7:0] b, input int nb, input bit release_valid,
                               input int n_change_cycle, input logic [3:0] n_new);
        int g;
        g = 0;
        for (int i = 0; i < FB; i++) begin
            for (int c = 0; c < nb; c++) begin
                if (g == n_change_cycle) n = n_new;
                chk($sformatf("txd_b%02h_bit%0d_c%0d", b, i, c), {31'd0, txd}, {31'd0, frame_bit(b, i)});
                chk($sformatf("busy_b%02h_g%0d", b, g), {31'd0, busy}, 32'd1);
                chk($sformatf("done_b%02h_g%0d", b, g), {31'd0, tx_done},
                    {31'd0, (i == FB - 1) && (c == nb - 1)});
                step();
                if (g == 0 && release_valid) begin
                    valid = 1'b0;
                    chk("ready_low_after_queue", {31'd0, ready}, 32'd0);
                end
                g++;
            end
        end
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {28'd0, txd, ready, busy, tx_done}, 32'b1100);
    endtask

    initial begin
        int len;
        int done_seen;
        logic stop_or_par;

        rst   = 1'b1;
        n     = 4'd4;
        data  = 8'h00;
        valid = 1'b0;
        step();
        step();
        chk_idle("reset_state");
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_idle($sformatf("idle_%0d", i));
        end

        // n=4, single byte 0xA5
        n     = 4'd4;
        data  = 8'hA5;
        valid = 1'b1;
        step();                     // accept edge
        valid = 1'b0;
        chk("a5_ready_after_accept", {31'd0, ready}, 32'd0);
        chk("a5_busy_after_accept",  {31'd0, busy},  32'd0);
        chk("a5_txd_after_accept",   {31'd0, txd},   32'd1);
        step();                     // transfer edge, START entered
        chk("a5_ready_after_xfer",   {31'd0, ready}, 32'd1);
        check_frame(8'hA5, 4, 1'b0, -1, 4'd0);
        chk_idle("a5_idle_after");

        // n=2, 0x07 then 0x80 with valid held high
        n     = 4'd2;
        data  = 8'h07;
        valid = 1'b1;
        step();
        data = 8'h80;
        chk("b2b_ready_low", {31'd0, ready}, 32'd0);
        step();
        chk("b2b_ready_at_start", {31'd0, ready}, 32'd1);
        check_frame(8'h07, 2, 1'b1, -1, 4'd0);
        check_frame(8'h80, 2, 1'b0, -1, 4'd0);
        chk_idle("b2b_idle_after");

        // n=0 acts as one cycle per bit
        n     = 4'd0;
        data  = 8'h5A;
        valid = 1'b1;
        step();
        valid = 1'b0;
        step();
        check_frame(8'h5A, 1, 1'b0, -1, 4'd0);
        chk_idle("n0_idle_after");

        // n=3, changed to 8 during DATA; queued second frame uses 8
        n     = 4'd3;
        data  = 8'hC3;
        valid = 1'b1;
        step();
        data = 8'h11;
        step();
        check_frame(8'hC3, 3, 1'b1, 6, 4'd8);
        check_frame(8'h11, 8, 1'b0, -1, 4'd0);
        chk_idle("nchg_idle_after");

        // reset during DATA bit 4 with a second byte queued
        n     = 4'd2;
        data  = 8'h96;
        valid = 1'b1;
        step();
        step();                     // frame cycle 0
        data = 8'h55;
        step();                     // frame cycle 1, 0x55 accepted
        valid = 1'b0;
        chk("rst_queued_ready_low", {31'd0, ready}, 32'd0);
        for (int i = 0; i < 9; i++) step();   // frame cycle 10 = d4
        chk("rst_txd_bit4", {31'd0, txd}, 32'd1);
        rst = 1'b1;
        step();
        chk_idle("rst_midframe");
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            chk($sformatf("rst_no_frame_%0d", i), {30'd0, txd, busy}, 32'b10);
        end

        // independent frame length measurement, n=4, 0x3C
        n     = 4'd4;
        data  = 8'h3C;
        valid = 1'b1;
        step();
        valid = 1'b0;
        step();
        len         = 0;
        done_seen   = 0;
        stop_or_par = 1'bx;
        while (busy && len < 200) begin
            if (tx_done) done_seen++;
            if (len == 36) stop_or_par = txd;
            len++;
            step();
        end
        chk("len_3c", len, 4 * FB);
        chk("done_count_3c", done_seen, 1);
`ifdef UART_TX_PARITY_EN
        chk("bit9_3c_parity", {31'd0, stop_or_par}, 32'd0);
`else
        chk("bit9_3c_stop", {31'd0, stop_or_par}, 32'd1);
`endif
        chk_idle("len_idle_after");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
